// File: rtl/band_level_meter_pkg.sv
// -----------------------------------------------------------------------------
// band_level_meter_pkg
// Shared definitions for the band level meter: band count, sample and level
// widths, band index width and the control FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package band_level_meter_pkg;

    localparam int NBANDS_C = 8;   // band count, fixed in this revision
    localparam int SAMPLE_W = 16;  // signed filter-bank sample width
    localparam int LEVEL_W  = 16;  // unsigned smoothed level width
    localparam int IDX_W    = 3;   // band index width (covers 0..NBANDS_C-1)

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic        [LEVEL_W-1:0]  level_t;
    typedef logic        [IDX_W-1:0]    band_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/band_level_meter_alu.sv
// -----------------------------------------------------------------------------
// band_level_alu
// Combinational magnitude + leaky-integrator step for one band:
//   mag       = |sample|, with -32768 saturating to 32767
//   new_level = old_level + ((mag - old_level) >>> SHIFT)   (17-bit signed)
// The arithmetic shift floors toward minus infinity, so the result always lies
// between old_level and mag and stays inside 0..32767.
// Ports:
//   sample_i  signed 16-bit band sample
//   level_i   current 16-bit unsigned level
//   level_o   updated 16-bit unsigned level
// -----------------------------------------------------------------------------
module band_level_alu
    import band_level_meter_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  sample_t sample_i,
    input  level_t  level_i,
    output level_t  level_o
);

    logic [LEVEL_W-1:0]   neg_w;
    logic [LEVEL_W-1:0]   mag_w;
    logic signed [16:0]   diff_w;
    logic signed [16:0]   step_w;
    logic signed [16:0]   sum_w;

    assign neg_w = ~sample_i + 16'd1;

    always_comb begin
        mag_w = sample_i;
        if (sample_i == 16'sh8000) begin
            // the only sample whose magnitude does not fit in 15 bits
            mag_w = 16'h7FFF;
        end else if (sample_i[15]) begin
            mag_w = neg_w;
        end
    end

    assign diff_w = $signed({1'b0, mag_w}) - $signed({1'b0, level_i});
    assign step_w = diff_w >>> SHIFT;
    assign sum_w  = $signed({1'b0, level_i}) + step_w;

    // sum_w cannot go negative for in-range levels; the guard only keeps a
    // corrupted level from wrapping to a huge value.
    assign level_o = sum_w[16] ? '0 : sum_w[15:0];

endmodule

// File: rtl/band_level_meter.sv
// -----------------------------------------------------------------------------
// band_level_meter
// Smoothed per-band magnitude meter for an 8-band filter bank. A frame strobe
// captures all eight samples; the FSM then walks bands 0..7, one per cycle,
// through one shared band_level_alu, updates that band's level, and tracks the
// largest updated level. A one-cycle DONE state publishes level_valid and the
// registered peak band index.
//
// Handshake: bands_valid_i is a strobe with no ready. It is accepted only in
// IDLE (busy_o low). A strobe while busy_o is high is dropped, the capture
// registers are untouched, and overrun_o pulses on the following cycle.
//
// Ports:
//   clk_i           sole clock, rising edge
//   rst_i           asynchronous active-high reset
//   bands_valid_i   new frame strobe
//   band0_i..7_i    signed 16-bit band samples
//   level0_o..7_o   unsigned 16-bit smoothed levels
//   level_valid_o   one-cycle strobe, all levels updated (DONE)
//   peak_band_o     index of the largest level after the last update
//   busy_o          high in PROC and DONE
//   overrun_o       one-cycle pulse after a strobe arrived while busy
//   state_o         current FSM state (debug)
// -----------------------------------------------------------------------------
module band_level_meter
    import band_level_meter_pkg::*;
#(
    parameter int SHIFT  = 4,
    parameter int NBANDS = NBANDS_C
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bands_valid_i,
    input  sample_t     band0_i,
    input  sample_t     band1_i,
    input  sample_t     band2_i,
    input  sample_t     band3_i,
    input  sample_t     band4_i,
    input  sample_t     band5_i,
    input  sample_t     band6_i,
    input  sample_t     band7_i,
    output level_t      level0_o,
    output level_t      level1_o,
    output level_t      level2_o,
    output level_t      level3_o,
    output level_t      level4_o,
    output level_t      level5_o,
    output level_t      level6_o,
    output level_t      level7_o,
    output logic        level_valid_o,
    output logic [2:0]  peak_band_o,
    output logic        busy_o,
    output logic        overrun_o,
    output state_e      state_o
);

    localparam band_idx_t LAST_IDX = band_idx_t'(NBANDS - 1);

    state_e    state_q, state_d;
    band_idx_t idx_q;
    sample_t   cap_q   [NBANDS];
    level_t    level_q [NBANDS];
    sample_t   band_w  [NBANDS];
    level_t    max_val_q;
    band_idx_t max_idx_q;
    band_idx_t peak_q;
    logic      overrun_q;

    sample_t   alu_sample_w;
    level_t    alu_old_w;
    level_t    alu_new_w;
    level_t    cand_val_w;
    band_idx_t cand_idx_w;

    logic      capture_w;
    logic      proc_step_w;
    logic      last_step_w;

    assign band_w[0] = band0_i;
    assign band_w[1] = band1_i;
    assign band_w[2] = band2_i;
    assign band_w[3] = band3_i;
    assign band_w[4] = band4_i;
    assign band_w[5] = band5_i;
    assign band_w[6] = band6_i;
    assign band_w[7] = band7_i;

    assign capture_w   = (state_q == ST_IDLE) && bands_valid_i;
    assign proc_step_w = (state_q == ST_PROC);
    assign last_step_w = proc_step_w && (idx_q == LAST_IDX);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bands_valid_i) state_d = ST_PROC;
            ST_PROC: if (idx_q == LAST_IDX) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------- band index
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q <= '0;
        end else if (capture_w) begin
            idx_q <= '0;
        end else if (proc_step_w) begin
            idx_q <= idx_q + 3'd1;
        end
    end

    // ------------------------------------------------ capture registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NBANDS; i++) cap_q[i] <= '0;
        end else if (capture_w) begin
            for (int i = 0; i < NBANDS; i++) cap_q[i] <= band_w[i];
        end
    end

    // ---------------------------------------------------- shared datapath
    assign alu_sample_w = cap_q[idx_q];
    assign alu_old_w    = level_q[idx_q];

    band_level_alu #(
        .SHIFT (SHIFT)
    ) u_alu (
        .sample_i (alu_sample_w),
        .level_i  (alu_old_w),
        .level_o  (alu_new_w)
    );

    // only the band being processed this cycle is written
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NBANDS; i++) level_q[i] <= '0;
        end else if (proc_step_w) begin
            level_q[idx_q] <= alu_new_w;
        end
    end

    // ------------------------------------------------------ peak tracker
    // Band 0 seeds the running maximum; later bands replace it only when
    // strictly larger, so ties stay with the lower index.
    always_comb begin
        cand_val_w = max_val_q;
        cand_idx_w = max_idx_q;
        if ((idx_q == '0) || (alu_new_w > max_val_q)) begin
            cand_val_w = alu_new_w;
            cand_idx_w = idx_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            max_val_q <= '0;
            max_idx_q <= '0;
            peak_q    <= '0;
        end else if (proc_step_w) begin
            max_val_q <= cand_val_w;
            max_idx_q <= cand_idx_w;
            if (last_step_w) begin
                peak_q <= cand_idx_w;
            end
        end
    end

    // ---------------------------------------------------------- overrun
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= bands_valid_i && (state_q != ST_IDLE);
        end
    end

    // ---------------------------------------------------------- outputs
    assign level0_o      = level_q[0];
    assign level1_o      = level_q[1];
    assign level2_o      = level_q[2];
    assign level3_o      = level_q[3];
    assign level4_o      = level_q[4];
    assign level5_o      = level_q[5];
    assign level6_o      = level_q[6];
    assign level7_o      = level_q[7];
    assign level_valid_o = (state_q == ST_DONE);
    assign busy_o        = (state_q != ST_IDLE);
    assign peak_band_o   = peak_q;
    assign overrun_o     = overrun_q;
    assign state_o       = state_q;

endmodule
